// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled asynchronous serial receiver.
// Frame: start(0), N_DATA data bits LSB first, optional parity, M_STOP stop bits.
// Handshake: o_rx_done is a one-clock strobe; o_data and both error flags are
// valid from the same clock edge and hold until the next strobe. There is no
// backpressure, so a consumer must capture them before the next frame completes.
module uart_rx #(
    parameter int NB_DATA         = 8,
    parameter int N_DATA          = 8,
    parameter int LOG2_N_DATA     = 4,
    parameter int PARITY_CHECK    = 0,
    parameter int EVEN_ODD_PARITY = 1,
    parameter int M_STOP          = 1,
    parameter int LOG2_M_STOP     = 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_data,
    input  logic               i_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done,
    output logic               o_parity_error,
    output logic               o_frame_error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     sync_1;
    logic                     line_s;
    logic                     armed;
    logic [3:0]               tick_cnt;
    logic [LOG2_N_DATA-1:0]   data_cnt;
    logic [LOG2_M_STOP-1:0]   stop_cnt;
    logic [NB_DATA-1:0]       data_reg;
    logic                     frame_err;
    logic                     parity_err;

    logic                     mid_tick;
    logic                     last_data;
    logic                     last_stop;
    logic                     enter_start;
    logic                     start_ok;
    logic                     data_sample;
    logic                     parity_sample;
    logic                     stop_sample;
    logic                     frame_done;
    logic                     exp_parity;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync_1 <= 1'b1;
            line_s <= 1'b1;
        end else begin
            sync_1 <= i_data;
            line_s <= sync_1;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= state_next;
    end

    assign last_data = (data_cnt == LOG2_N_DATA'(N_DATA - 1));
    assign last_stop = (stop_cnt == LOG2_M_STOP'(M_STOP - 1));

    // Next-state logic; the FSM only moves on baud ticks.
    always_comb begin
        state_next = state;
        if (i_valid) begin
            case (state)
                IDLE:    if (!line_s && armed) state_next = START;
                START:   if (tick_cnt == 4'd7) state_next = line_s ? IDLE : DATA;
                DATA:    if (tick_cnt == 4'd15 && last_data)
                             state_next = (PARITY_CHECK != 0) ? PARITY : STOP;
                PARITY:  if (tick_cnt == 4'd15) state_next = STOP;
                STOP:    if (tick_cnt == 4'd15 && last_stop) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Per-state sampling strobes decoded from the current state and tick count.
    always_comb begin
        mid_tick      = i_valid && (tick_cnt == 4'd15);
        enter_start   = i_valid && (state == IDLE) && !line_s && armed;
        start_ok      = i_valid && (state == START) && (tick_cnt == 4'd7) && !line_s;
        data_sample   = mid_tick && (state == DATA);
        parity_sample = mid_tick && (state == PARITY);
        stop_sample   = mid_tick && (state == STOP);
        frame_done    = stop_sample && last_stop;
        // data_reg is cleared at frame start, so bits above N_DATA do not affect this.
        exp_parity    = (EVEN_ODD_PARITY != 0) ? ^data_reg : ~^data_reg;
    end

    // Tick, data-bit and stop-bit counters.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tick_cnt <= '0;
            data_cnt <= '0;
            stop_cnt <= '0;
        end else begin
            if (enter_start || start_ok)
                tick_cnt <= '0;
            else if (i_valid && state != IDLE)
                tick_cnt <= tick_cnt + 4'd1;

            if (start_ok)
                data_cnt <= '0;
            else if (data_sample)
                data_cnt <= data_cnt + 1'b1;

            if (start_ok)
                stop_cnt <= '0;
            else if (stop_sample)
                stop_cnt <= stop_cnt + 1'b1;
        end
    end

    // Shift register, error flags and the armed flag that blocks re-triggering on a break.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            data_reg   <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            armed      <= 1'b0;
        end else begin
            if (start_ok) begin
                data_reg   <= '0;
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
            if (data_sample) begin
                for (int i = 0; i < N_DATA; i++) begin
                    if (data_cnt == LOG2_N_DATA'(i)) data_reg[i] <= line_s;
                end
            end
            if (parity_sample)
                parity_err <= (PARITY_CHECK != 0) && (line_s != exp_parity);
            if (stop_sample && !line_s)
                frame_err <= 1'b1;

            if (i_valid && line_s)
                armed <= 1'b1;
            else if (stop_sample && !line_s)
                armed <= 1'b0;
        end
    end

    // Output registers: strobe plus word and flags, all updated on frame completion.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_rx_done      <= 1'b0;
            o_data         <= '0;
            o_parity_error <= 1'b0;
            o_frame_error  <= 1'b0;
        end else begin
            o_rx_done <= frame_done;
            if (frame_done) begin
                o_data         <= data_reg;
                o_parity_error <= parity_err && (PARITY_CHECK != 0);
                o_frame_error  <= frame_err || !line_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into an 8N1 receiver and an 8E1 receiver.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] data_a, data_b;
    logic       done_a, done_b;
    logic       perr_a, perr_b;
    logic       ferr_a, ferr_b;

    int n_vec = 0;
    int n_err = 0;
    int tick_num = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    int         pulse_tick_q[$];
    logic [7:0] pulse_data_q[$];

    // Clock generation.
    always #5 clk = ~clk;

    uart_rx dut_a (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_data         (rx_a),
        .i_valid        (valid),
        .o_data         (data_a),
        .o_rx_done      (done_a),
        .o_parity_error (perr_a),
        .o_frame_error  (ferr_a)
    );

    uart_rx #(.PARITY_CHECK(1), .EVEN_ODD_PARITY(1)) dut_b (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_data         (rx_b),
        .i_valid        (valid),
        .o_data         (data_b),
        .o_rx_done      (done_b),
        .o_parity_error (perr_b),
        .o_frame_error  (ferr_b)
    );

    // Pulse monitor: records every done strobe away from the active edge.
    always @(negedge clk) begin
        if (done_a) begin
            pulses_a = pulses_a + 1;
            pulse_tick_q.push_back(tick_num);
            pulse_data_q.push_back(data_a);
        end
        if (done_b) pulses_b = pulses_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One baud tick every three clocks; line changes settle through the synchronizer first.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (2) @(negedge clk);
            valid = 1'b1;
            tick_num++;
            @(negedge clk);
            valid = 1'b0;
        end
    endtask

    task automatic drive_bit(input bit sel, input logic b);
        if (sel) rx_b = b;
        else     rx_a = b;
        tick_n(16);
    endtask

    task automatic send_a(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, d[i]);
        drive_bit(1'b0, stop_bit);
    endtask

    task automatic send_b(input logic [7:0] d, input logic par);
        drive_bit(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b1, d[i]);
        drive_bit(1'b1, par);
        drive_bit(1'b1, 1'b1);
    endtask

    initial begin
        int p0;
        rst_n = 1'b0;
        valid = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data",  {24'd0, data_a}, 32'h0);
        check("reset_done",  {31'd0, done_a}, 32'h0);
        check("reset_perr",  {31'd0, perr_b}, 32'h0);
        check("reset_ferr",  {31'd0, ferr_a}, 32'h0);
        rst_n = 1'b1;
        tick_n(20);

        // 8N1 frame 0xA5.
        send_a(8'hA5, 1'b1);
        tick_n(8);
        check("a5_pulses", pulses_a, 1);
        check("a5_data",   {24'd0, data_a}, 32'hA5);
        check("a5_perr",   {31'd0, perr_a}, 32'h0);
        check("a5_ferr",   {31'd0, ferr_a}, 32'h0);

        // Even parity: 0x07 has three ones, so the correct parity bit is 1.
        send_b(8'h07, 1'b1);
        tick_n(8);
        check("par_ok_pulses", pulses_b, 1);
        check("par_ok_data",   {24'd0, data_b}, 32'h07);
        check("par_ok_perr",   {31'd0, perr_b}, 32'h0);
        send_b(8'h07, 1'b0);
        tick_n(8);
        check("par_bad_pulses", pulses_b, 2);
        check("par_bad_data",   {24'd0, data_b}, 32'h07);
        check("par_bad_perr",   {31'd0, perr_b}, 32'h1);
        check("par_bad_ferr",   {31'd0, ferr_b}, 32'h0);

        // Back-to-back 0x55, 0xFF with no idle gap: pulses exactly 160 ticks apart.
        pulse_tick_q.delete();
        pulse_data_q.delete();
        send_a(8'h55, 1'b1);
        send_a(8'hFF, 1'b1);
        tick_n(8);
        check("b2b_count", pulse_tick_q.size(), 2);
        if (pulse_tick_q.size() >= 2) begin
            check("b2b_gap",   pulse_tick_q[1] - pulse_tick_q[0], 160);
            check("b2b_data0", {24'd0, pulse_data_q[0]}, 32'h55);
            check("b2b_data1", {24'd0, pulse_data_q[1]}, 32'hFF);
        end

        // Stop bit low on 0x3C, then line held low for 40 bit times.
        p0 = pulses_a;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, (8'h3C >> i) & 8'h01);
        drive_bit(1'b0, 1'b0);
        check("brk_pulse", pulses_a, p0 + 1);
        check("brk_data",  {24'd0, data_a}, 32'h3C);
        check("brk_ferr",  {31'd0, ferr_a}, 32'h1);
        tick_n(40 * 16);
        check("brk_quiet", pulses_a, p0 + 1);
        rx_a = 1'b1;
        tick_n(32);
        check("brk_release", pulses_a, p0 + 1);

        // Four-tick low glitch on the idle line.
        rx_a = 1'b0;
        tick_n(4);
        rx_a = 1'b1;
        tick_n(40);
        check("glitch_pulses", pulses_a, p0 + 1);
        check("glitch_data",   {24'd0, data_a}, 32'h3C);
        check("glitch_ferr",   {31'd0, ferr_a}, 32'h1);

        // Reset during data bit 3 of 0x81.
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        rx_a = 1'b0;
        tick_n(5);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_data", {24'd0, data_a}, 32'h0);
        check("rst_mid_done", {31'd0, done_a}, 32'h0);
        check("rst_mid_ferr", {31'd0, ferr_a}, 32'h0);
        check("rst_mid_perr", {31'd0, perr_b}, 32'h0);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick_n(20);
        check("rst_no_pulse", pulses_a, p0 + 1);
        send_a(8'h81, 1'b1);
        tick_n(8);
        check("post_rst_pulse", pulses_a, p0 + 2);
        check("post_rst_data",  {24'd0, data_a}, 32'h81);
        check("post_rst_ferr",  {31'd0, ferr_a}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver. Counterpart of the team's uart_tx; shares the same frame format and parameter set.
- Deframes an asynchronous serial line into parallel words using a 16x oversampling tick on i_valid.
- Pulses o_rx_done with status flags on each received frame.
- Sits between the board RX pin and the interface/ALU control logic.

Parameters:
- NB_DATA, 8, width of o_data.
- N_DATA, 8, data bits per frame (1..NB_DATA).
- LOG2_N_DATA, 4, width of the data-bit counter; must satisfy 2^LOG2_N_DATA > N_DATA.
- PARITY_CHECK, 0, 1 = one parity bit follows the data bits.
- EVEN_ODD_PARITY, 1, 1 = expected parity bit is ^data (even); 0 = ~^data (odd).
- M_STOP, 1, stop bits per frame (1..2).
- LOG2_M_STOP, 1, width of the stop-bit counter.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_data  in  1  serial line; idles high.
- i_valid  in  1  baud tick, 16 per bit period; one i_clock wide.
- o_data  out  NB_DATA  last received word, right-justified, upper bits 0.
- o_rx_done  out  1  one-i_clock pulse when a frame completes.
- o_parity_error  out  1  parity mismatch in the last frame.
- o_frame_error  out  1  a stop bit sampled low in the last frame.

Behaviour:
- Reset: while i_reset=0, all state is asynchronously cleared.
  - o_data=0, o_rx_done=0, o_parity_error=0, o_frame_error=0.
  - FSM in IDLE; synchronizer flops set to 1; all counters 0.
  - Reset asserted mid-frame aborts the frame; no done pulse is produced.
- Input synchronization: i_data passes through a 2-flop synchronizer (runs every clock). All sampling uses the synchronized value.
- Gating: tick counter (4 bit), bit counters and FSM advance only on clocks with i_valid=1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: line low and armed -> START, tick counter cleared. Armed flag is set whenever the line is sampled high.
  - START: at tick 7 (mid start bit):
    - line 0 -> DATA; tick counter and data counter cleared.
    - line 1 -> glitch, back to IDLE; no flags change.
  - DATA: every 16 ticks (counter reaching 15, then wrapping to 0) sample the line. Bit k is written to the data register index k (LSB first).
    - After N_DATA samples -> PARITY if PARITY_CHECK=1, else STOP (stop counter cleared).
  - PARITY: at tick 15 sample the bit. Parity error = sampled != expected, where expected is computed over the N_DATA received bits. Then -> STOP.
  - STOP: at tick 15 sample each stop bit.
    - Any low sample sets the internal frame-error flag and clears armed.
    - After M_STOP samples -> IDLE and frame completes.
- Frame completion (the clock on which the last stop sample is taken):
  - Next clock: o_rx_done=1 for exactly one i_clock.
  - o_data, o_parity_error and o_frame_error update on the same edge and hold until the next completion.
- Latency: o_rx_done rises 1 clock after the mid-point sample of the last stop bit.
- Break (line stuck low): produces one frame with o_frame_error=1, o_data=0. No further frames until the line has been seen high (armed).
- Parity flags are forced to 0 when PARITY_CHECK=0.
- A start edge arriving in the same clock as the completion pulse is accepted: the FSM is already in IDLE and the pulse is independent of FSM progress.

Test Plan:
- Send 0xA5, 8N1, 16 ticks/bit -> one o_rx_done pulse; o_data=0xA5; both errors 0.
- PARITY_CHECK=1, EVEN_ODD_PARITY=1:
  - Send 0x07 with parity bit 1 -> o_data=0x07, o_parity_error=0.
  - Repeat with parity bit 0 -> o_parity_error=1, o_data=0x07.
- Stop bit driven 0 on frame 0x3C -> o_frame_error=1, o_data=0x3C. Line then held low 40 bit-times -> no further o_rx_done until the line returns high.
- Low glitch of 4 ticks on the idle line -> FSM returns to IDLE; no o_rx_done; outputs unchanged.
- Back-to-back frames 0x55 then 0xFF with zero idle gap, M_STOP=1 -> two pulses exactly 160 ticks apart; o_data=0x55 then 0xFF.
- Assert i_reset=0 during data bit 3 -> all outputs 0 immediately (asynchronous). After release, send 0x81 -> o_data=0x81 correct.
